// File: rtl/adder_host_sequencer_if.sv
// adder_host_sequencer_if
//
// Bundles the three signal groups around the adder host sequencer:
//   request  : req_valid, req_ready, req_a, req_b
//   adder    : add_start, add_a, add_b, add_done, add_result
//   response : rsp_valid, rsp_ready, rsp_data, rsp_err
//
// Modports:
//   master : the sequencer. It drives req_ready, the adder operand bus and
//            start, and the response channel.
//   slave  : the surroundings. They are the request fabric, the adder and the
//            response consumer.
interface adder_host_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             add_start;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_done;
    logic [WIDTH-1:0] add_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        input  req_valid, req_a, req_b, add_done, add_result, rsp_ready,
        output req_ready, add_start, add_a, add_b, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        output req_valid, req_a, req_b, add_done, add_result, rsp_ready,
        input  req_ready, add_start, add_a, add_b, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/adder_host_sequencer.sv
// adder_host_sequencer
//
// This is the initiator side of the serial adder's start/done handshake. It
// accepts one operand pair on the request port and loads it onto the adder
// operand bus. It then pulses add_start for START_CYCLES cycles. It follows
// add_done low and back high, and then returns the captured sum on the
// response port. Only one operation is in flight at a time.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (shared with the adder)
//   bus  : adder_host_sequencer_if.master (request / adder / response groups)
//
// Parameters:
//   WIDTH        : operand / result width
//   START_CYCLES : cycles add_start is held high (1..15)
//   TIMEOUT      : cycle budget in RELEASE+WAIT. It applies only when the
//                  optional timeout is built in.
//
// Optional feature: define ADDER_HOST_TIMEOUT_EN to abort an operation that
// has not completed within TIMEOUT cycles of entering RELEASE. The aborted
// operation still produces a response, with rsp_err=1 and rsp_data=0. Without
// the macro, rsp_err is tied low and the sequencer waits forever.
module adder_host_sequencer #(
    parameter int WIDTH        = 16,
    parameter int START_CYCLES = 1,
    parameter int TIMEOUT      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_host_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_reg;
    logic [3:0]       start_cnt_reg;
    logic             add_start_reg;
    logic [WIDTH-1:0] add_a_reg;
    logic [WIDTH-1:0] add_b_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_data_reg;

`ifdef ADDER_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_reg;
    logic            rsp_err_reg;
    logic            to_hit;

    // The counter value is the number of completed cycles spent in RELEASE
    // and WAIT. The edge that would bring it to TIMEOUT is the abort edge.
    assign to_hit      = (to_cnt_reg == TO_W'(TIMEOUT - 1));
    assign bus.rsp_err = rsp_err_reg;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // An accept is offered only when the adder is idle. A new operation
    // therefore never overlaps the tail of a previous one.
    assign bus.req_ready = (state_reg == S_IDLE) && bus.add_done;
    assign bus.add_start = add_start_reg;
    assign bus.add_a     = add_a_reg;
    assign bus.add_b     = add_b_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            start_cnt_reg <= 4'd0;
            add_start_reg <= 1'b0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
`ifdef ADDER_HOST_TIMEOUT_EN
            to_cnt_reg    <= '0;
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // Operands are written only here. This keeps them stable
                    // through the adder's load cycle and until the next accept.
                    if (bus.req_valid && bus.add_done) begin
                        add_a_reg     <= bus.req_a;
                        add_b_reg     <= bus.req_b;
                        add_start_reg <= 1'b1;
                        start_cnt_reg <= 4'd1;
                        state_reg     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // start_cnt_reg counts the start-high cycles that have
                    // already begun, including the current one.
                    if (start_cnt_reg == 4'(START_CYCLES)) begin
                        add_start_reg <= 1'b0;
                        state_reg     <= S_RELEASE;
`ifdef ADDER_HOST_TIMEOUT_EN
                        to_cnt_reg    <= '0;
`endif
                    end else begin
                        start_cnt_reg <= start_cnt_reg + 4'd1;
                    end
                end

                S_RELEASE: begin
`ifdef ADDER_HOST_TIMEOUT_EN
                    if (to_hit) begin
                        rsp_data_reg  <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                        if (!bus.add_done) begin
                            state_reg <= S_WAIT;
                        end
                    end
`else
                    if (!bus.add_done) begin
                        state_reg <= S_WAIT;
                    end
`endif
                end

                S_WAIT: begin
                    // A completion has priority over a timeout on the same edge.
                    if (bus.add_done) begin
                        rsp_data_reg  <= bus.add_result;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
`ifdef ADDER_HOST_TIMEOUT_EN
                        rsp_err_reg   <= 1'b0;
`endif
                    end
`ifdef ADDER_HOST_TIMEOUT_EN
                    else if (to_hit) begin
                        rsp_data_reg  <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
`endif
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_host_sequencer.sv
// tb_adder_host_sequencer
//
// This bench runs three sequencer instances, each driving a behavioural serial
// adder:
//   inst0 : START_CYCLES=1, real adder
//   inst1 : START_CYCLES=3, real adder
//   inst2 : TIMEOUT=8, adder that drops add_done and never raises it again
// A transaction-level model predicts, per instance, when add_start is high,
// when the response appears, and what it carries. The prediction is made from
// the accept cycle and the expected latency. The model is checked on every
// negedge. Directed stimulus adds hand-computed literal expectations.
module tb_adder_host_sequencer;
    localparam int W = 16;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    // stimulus side
    logic [N-1:0] rv = '0;
    logic [N-1:0] rr = '0;
    logic [W-1:0] ra [N] = '{default: '0};
    logic [W-1:0] rb [N] = '{default: '0};

    // observed DUT outputs
    logic [N-1:0] o_ready, o_start, o_valid, o_err;
    logic [W-1:0] o_a [N];
    logic [W-1:0] o_b [N];
    logic [W-1:0] o_data [N];

    // behavioural adder state
    logic [N-1:0] ad_done;
    logic [W-1:0] ad_res [N];
    int           ad_st  [N];
    int           ad_cnt [N];

    adder_host_sequencer_if #(.WIDTH(W)) bus0 ();
    adder_host_sequencer_if #(.WIDTH(W)) bus1 ();
    adder_host_sequencer_if #(.WIDTH(W)) bus2 ();

    adder_host_sequencer #(.WIDTH(W), .START_CYCLES(1), .TIMEOUT(64)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    adder_host_sequencer #(.WIDTH(W), .START_CYCLES(3), .TIMEOUT(64)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    adder_host_sequencer #(.WIDTH(W), .START_CYCLES(1), .TIMEOUT(8))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus0.req_valid = rv[0];  assign bus0.req_a = ra[0];  assign bus0.req_b = rb[0];
    assign bus0.rsp_ready = rr[0];  assign bus0.add_done = ad_done[0];  assign bus0.add_result = ad_res[0];
    assign o_ready[0] = bus0.req_ready;  assign o_start[0] = bus0.add_start;  assign o_valid[0] = bus0.rsp_valid;
    assign o_err[0] = bus0.rsp_err;  assign o_a[0] = bus0.add_a;  assign o_b[0] = bus0.add_b;  assign o_data[0] = bus0.rsp_data;

    assign bus1.req_valid = rv[1];  assign bus1.req_a = ra[1];  assign bus1.req_b = rb[1];
    assign bus1.rsp_ready = rr[1];  assign bus1.add_done = ad_done[1];  assign bus1.add_result = ad_res[1];
    assign o_ready[1] = bus1.req_ready;  assign o_start[1] = bus1.add_start;  assign o_valid[1] = bus1.rsp_valid;
    assign o_err[1] = bus1.rsp_err;  assign o_a[1] = bus1.add_a;  assign o_b[1] = bus1.add_b;  assign o_data[1] = bus1.rsp_data;

    assign bus2.req_valid = rv[2];  assign bus2.req_a = ra[2];  assign bus2.req_b = rb[2];
    assign bus2.rsp_ready = rr[2];  assign bus2.add_done = ad_done[2];  assign bus2.add_result = ad_res[2];
    assign o_ready[2] = bus2.req_ready;  assign o_start[2] = bus2.add_start;  assign o_valid[2] = bus2.rsp_valid;
    assign o_err[2] = bus2.rsp_err;  assign o_a[2] = bus2.add_a;  assign o_b[2] = bus2.add_b;  assign o_data[2] = bus2.rsp_data;

    // Serial adder behaviour: idle(done=1) -> START while start is high ->
    // 1 INIT cycle -> 16 ADD cycles -> idle with the sum registered.
    // Instance 2 never leaves ADD.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                ad_st[i]   <= 0;
                ad_cnt[i]  <= 0;
                ad_done[i] <= 1'b1;
                ad_res[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                case (ad_st[i])
                    0: if (o_start[i]) begin ad_st[i] <= 1; ad_done[i] <= 1'b0; end
                    1: if (!o_start[i]) ad_st[i] <= 2;
                    2: begin ad_st[i] <= 3; ad_cnt[i] <= 0; end
                    default: begin
                        if (i != 2) begin
                            if (ad_cnt[i] == 15) begin
                                ad_st[i]   <= 0;
                                ad_done[i] <= 1'b1;
                                ad_res[i]  <= o_a[i] + o_b[i];
                            end else begin
                                ad_cnt[i] <= ad_cnt[i] + 1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Transaction model: accept-cycle bookkeeping plus expected latencies.
    function automatic int start_len(int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic int lat_of(int i);
        if (i == 1) return 22;
        if (i == 2) begin
`ifdef ADDER_HOST_TIMEOUT_EN
            return 9;
`else
            return 1 << 30;
`endif
        end
        return 20;
    endfunction

    logic [N-1:0] m_busy, m_hung;
    int           m_c0 [N];
    logic [W-1:0] m_a  [N];
    logic [W-1:0] m_b  [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] <= 1'b0;
                m_hung[i] <= 1'b0;
                m_c0[i]   <= 0;
                m_a[i]    <= '0;
                m_b[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!m_busy[i] && !m_hung[i] && rv[i]) begin
                    m_busy[i] <= 1'b1;
                    m_c0[i]   <= cyc + 1;
                    m_a[i]    <= ra[i];
                    m_b[i]    <= rb[i];
                    if (i == 2) m_hung[i] <= 1'b1;
                end else if (m_busy[i] && (cyc - m_c0[i]) >= lat_of(i) && rr[i]) begin
                    m_busy[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s inst%0d cyc=%0d: got %h, expected %h", name, inst, cyc, act, exp);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            int         d;
            logic       e_valid;
            logic [W-1:0] e_sum;
            d       = cyc - m_c0[i];
            e_valid = m_busy[i] && (d >= lat_of(i));
            e_sum   = m_a[i] + m_b[i];
            chk("req_ready", i, 32'(o_ready[i]), 32'(!m_busy[i] && !m_hung[i]));
            chk("add_start", i, 32'(o_start[i]), 32'(m_busy[i] && d < start_len(i)));
            chk("rsp_valid", i, 32'(o_valid[i]), 32'(e_valid));
            chk("add_a", i, 32'(o_a[i]), 32'(m_a[i]));
            chk("add_b", i, 32'(o_b[i]), 32'(m_b[i]));
            if (e_valid) begin
                chk("rsp_data", i, 32'(o_data[i]), (i == 2) ? 32'd0 : 32'(e_sum));
                chk("rsp_err", i, 32'(o_err[i]), (i == 2) ? 32'd1 : 32'd0);
            end
        end
    end

    // Stimulus
    int acc [N];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got;
        got   = 1'b0;
        rv[i] = 1'b1;
        ra[i] = a;
        rb[i] = b;
        for (int k = 0; k < 200; k++) begin
            if (o_ready[i]) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk("accept_bound", i, 32'(got), 32'd1);
        acc[i] = cyc + 1;
        step();
        rv[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, input int max_cyc, output bit found,
                            output int lat, output int starts);
        found  = 1'b0;
        lat    = -1;
        starts = 0;
        for (int k = 0; k < max_cyc; k++) begin
            if (o_start[i]) starts++;
            if (o_valid[i]) begin
                found = 1'b1;
                lat   = cyc - acc[i];
                break;
            end
            step();
        end
        if (found)
            $display("txn inst%0d a=%h b=%h -> data=%h err=%0d lat=%0d",
                     i, o_a[i], o_b[i], o_data[i], o_err[i], lat);
        else
            $display("txn inst%0d a=%h b=%h -> no response within %0d cycles",
                     i, o_a[i], o_b[i], max_cyc);
    endtask

    initial begin
        bit          found;
        int          lat, starts, seen;
        logic [W-1:0] r0, r1;

        // reset
        repeat (3) step();
        rst = 1'b0;
        chk("rst_req_ready", 0, 32'(o_ready[0]), 32'd1);
        chk("rst_add_start", 0, 32'(o_start[0]), 32'd0);
        chk("rst_rsp_valid", 0, 32'(o_valid[0]), 32'd0);
        chk("rst_rsp_err",   0, 32'(o_err[0]),   32'd0);
        chk("rst_rsp_data",  0, 32'(o_data[0]),  32'd0);
        chk("rst_add_a",     0, 32'(o_a[0]),     32'd0);
        chk("rst_add_b",     0, 32'(o_b[0]),     32'd0);

        // single op with back-pressure
        rr[0] = 1'b0;
        send(0, 16'h1234, 16'h0F0F);
        wait_rsp(0, 100, found, lat, starts);
        chk("single_found",  0, 32'(found),     32'd1);
        chk("single_lat",    0, 32'(lat),       32'd20);
        chk("single_starts", 0, 32'(starts),    32'd1);
        chk("single_data",   0, 32'(o_data[0]), 32'h2143);
        chk("single_err",    0, 32'(o_err[0]),  32'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_valid", 0, 32'(o_valid[0]), 32'd1);
            chk("bp_data",  0, 32'(o_data[0]),  32'h2143);
            chk("bp_ready", 0, 32'(o_ready[0]), 32'd0);
        end
        rr[0] = 1'b1;
        step();
        chk("retire_ready", 0, 32'(o_ready[0]), 32'd1);
        chk("retire_valid", 0, 32'(o_valid[0]), 32'd0);

        // back-to-back requests
        fork
            begin
                send(0, 16'hFFFF, 16'h0001);
                send(0, 16'h00AA, 16'h0055);
            end
            begin
                bit f0, f1;
                int l0, s0;
                wait_rsp(0, 100, f0, l0, s0);
                r0 = o_data[0];
                step();
                wait_rsp(0, 100, f1, l0, s0);
                r1 = o_data[0];
                step();
                chk("b2b_found", 0, 32'({f0, f1}), 32'b11);
            end
        join
        chk("b2b_rsp0", 0, 32'(r0), 32'h0000);
        chk("b2b_rsp1", 0, 32'(r1), 32'h00FF);

        // START_CYCLES = 3
        rr[1] = 1'b1;
        send(1, 16'h0003, 16'h0004);
        wait_rsp(1, 100, found, lat, starts);
        chk("s3_found",  1, 32'(found),     32'd1);
        chk("s3_lat",    1, 32'(lat),       32'd22);
        chk("s3_starts", 1, 32'(starts),    32'd3);
        chk("s3_data",   1, 32'(o_data[1]), 32'h0007);
        step();

        // reset in the middle of WAIT
        send(0, 16'h1111, 16'h2222);
        repeat (8) step();
        rst = 1'b1;
        step();
        chk("midrst_valid", 0, 32'(o_valid[0]), 32'd0);
        chk("midrst_ready", 0, 32'(o_ready[0]), 32'd1);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (o_valid[0]) seen++;
        end
        chk("midrst_no_rsp", 0, 32'(seen), 32'd0);

        // hung adder
        rr[2] = 1'b0;
        send(2, 16'h0005, 16'h0006);
        wait_rsp(2, 40, found, lat, starts);
`ifdef ADDER_HOST_TIMEOUT_EN
        chk("to_found", 2, 32'(found),     32'd1);
        chk("to_lat",   2, 32'(lat),       32'd9);
        chk("to_err",   2, 32'(o_err[2]),  32'd1);
        chk("to_data",  2, 32'(o_data[2]), 32'd0);
        rr[2] = 1'b1;
        step();
        chk("to_retire", 2, 32'(o_valid[2]), 32'd0);
`else
        chk("hang_no_rsp", 2, 32'(found), 32'd0);
`endif
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
